// File: rtl/tmds_decoder_pkg.sv
// Shared constants for the TMDS decoder: control tokens, alignment FSM encoding,
// bit-slip offset width.
package tmds_decoder_pkg;

  localparam int OFFSET_W = 4;

  localparam logic [9:0] TOK_C00 = 10'h354;
  localparam logic [9:0] TOK_C01 = 10'h0AB;
  localparam logic [9:0] TOK_C10 = 10'h154;
  localparam logic [9:0] TOK_C11 = 10'h2AB;

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b symbol decode: control token detection plus TMDS data
// (DC-balance un-inversion and XOR/XNOR chain reversal).
module tmds_symbol_decode
  import tmds_decoder_pkg::*;
(
  input  logic [9:0] sym,
  output logic [7:0] data,
  output logic [1:0] c,
  output logic       is_token
);

  logic [7:0] d;

  assign d = sym[9] ? ~sym[7:0] : sym[7:0];

  always_comb begin
    data     = 8'h00;
    c        = 2'b00;
    is_token = 1'b1;
    case (sym)
      TOK_C00: c = 2'b00;
      TOK_C01: c = 2'b01;
      TOK_C10: c = 2'b10;
      TOK_C11: c = 2'b11;
      default: begin
        is_token = 1'b0;
        data[0]  = d[0];
        for (int i = 1; i < 8; i++)
          data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder with blanking-run based word alignment (bit slip search).
// Optional saturating error counter enabled by TMDS_DECODER_ERRCNT_EN.
module tmds_decoder
  import tmds_decoder_pkg::*;
#(
  parameter int C_window = 2048,
  parameter int C_run    = 8,
  parameter int C_loss   = 4
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic [9:0]          in_word,
  output logic [7:0]          out_data,
  output logic [1:0]          out_c,
  output logic                out_de,
  output logic                locked,
  output logic [OFFSET_W-1:0] offset
`ifdef TMDS_DECODER_ERRCNT_EN
  ,
  output logic [15:0]         err_count
`endif
);

  localparam int WIN_W  = (C_window > 2) ? $clog2(C_window) : 1;
  localparam int RUN_W  = $clog2(C_run + 1);
  localparam int LOSS_W = $clog2(C_loss + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(C_window - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(C_run);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(C_run - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(C_loss - 1);

  logic [19:0]       hist;
  logic [19:0]       hist_nxt;
  logic [9:0]        aligned;
  logic [0:0]        state;
  logic [WIN_W-1:0]  win_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [LOSS_W-1:0] loss_cnt;
  logic              run_seen;

  logic [7:0] dec_data;
  logic [1:0] dec_c;
  logic       dec_tok;
  logic       run_ev;
  logic       win_end;
  logic       slip;
  logic       miss;

  assign hist_nxt = {in_word, hist[19:10]};

  tmds_symbol_decode u_dec (
    .sym      (aligned),
    .data     (dec_data),
    .c        (dec_c),
    .is_token (dec_tok)
  );

  // A run event wins over a simultaneous window expiry.
  assign run_ev  = dec_tok && (run_cnt == RUN_LAST);
  assign win_end = (win_cnt == WIN_LAST);
  assign slip    = (state == ST_SEARCH) && win_end && !run_ev;
  assign miss    = (state == ST_LOCKED) && win_end && !(run_seen || run_ev);
  assign locked  = (state == ST_LOCKED);

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hist     <= '0;
      aligned  <= '0;
      out_data <= '0;
      out_c    <= '0;
      out_de   <= 1'b0;
      state    <= ST_SEARCH;
      offset   <= '0;
      win_cnt  <= '0;
      run_cnt  <= '0;
      loss_cnt <= '0;
      run_seen <= 1'b0;
    end else begin
      hist <= hist_nxt;
      // Slice the post-shift history so in_word reaches the outputs in 3 edges.
      aligned <= hist_nxt[offset +: 10];

      if (dec_tok) begin
        out_de   <= 1'b0;
        out_data <= 8'h00;
        out_c    <= dec_c;
      end else begin
        out_de   <= 1'b1;
        out_data <= dec_data;
      end

      if (!dec_tok)
        run_cnt <= '0;
      else if (run_cnt != RUN_MAX)
        run_cnt <= run_cnt + 1'b1;

      win_cnt <= win_end ? '0 : win_cnt + 1'b1;

      case (state)
        ST_SEARCH: begin
          if (run_ev) begin
            state    <= ST_LOCKED;
            win_cnt  <= '0;
            loss_cnt <= '0;
            run_seen <= 1'b0;
          end else if (win_end) begin
            offset  <= (offset == OFFSET_W'(9)) ? '0 : offset + 1'b1;
            run_cnt <= '0;
          end
        end
        default: begin
          if (win_end) begin
            run_seen <= 1'b0;
            if (run_seen || run_ev) begin
              loss_cnt <= '0;
            end else if (loss_cnt == LOSS_LAST) begin
              state    <= ST_SEARCH;
              loss_cnt <= '0;
            end else begin
              loss_cnt <= loss_cnt + 1'b1;
            end
          end else if (run_ev) begin
            run_seen <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef TMDS_DECODER_ERRCNT_EN
  always_ff @(posedge clk_pixel) begin
    if (reset)
      err_count <= '0;
    else if ((slip || miss) && (err_count != 16'hFFFF))
      err_count <= err_count + 1'b1;
  end
`else
  logic unused_err;
  assign unused_err = slip ^ miss;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: reset, phase-0 lock, data/token decode, loss of
// lock, 3-bit slip search, run on window expiry, and reset while locked.
module tb_tmds_decoder;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [9:0] in_word;
  logic [7:0] out_data;
  logic [1:0] out_c;
  logic       out_de;
  logic       locked;
  logic [3:0] offset;
`ifdef TMDS_DECODER_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  tmds_decoder dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .in_word   (in_word),
    .out_data  (out_data),
    .out_c     (out_c),
    .out_de    (out_de),
    .locked    (locked),
    .offset    (offset)
`ifdef TMDS_DECODER_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge with w on the input; outputs are sampled 1 time unit later.
  task automatic drive(input logic [9:0] w);
    in_word = w;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_offset"}, 32'(offset), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_c"}, 32'(out_c), 32'd0);
    chk({tag, "_de"}, 32'(out_de), 32'd0);
  endtask

  logic [9:0] tok0;
  logic [9:0] wd3;
  logic [9:0] dw    [10];
  logic [7:0] ex_d  [10];
  logic [1:0] ex_c  [10];
  logic       ex_de [10];

  initial begin
    tok0  = 10'h354;
    wd3   = {tok0[6:0], tok0[9:7]};
    dw    = '{10'h1FF, 10'h100, 10'h0FF, 10'h2FF, 10'h0AB,
              10'h154, 10'h2AB, 10'h1FF, 10'h1A5, 10'h2A5};
    ex_d  = '{8'h01, 8'h00, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h01, 8'hEF, 8'h10};
    ex_c  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    ex_de = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    reset   = 1'b1;
    in_word = 10'h000;
    repeat (3) drive(10'h000);
    chk_zero("reset");
`ifdef TMDS_DECODER_ERRCNT_EN
    chk("reset_err", 32'(err_count), 32'd0);
`endif
    reset = 1'b0;

    // Phase-0 token stream: lock on edge C_run+2.
    for (int j = 1; j <= 12; j++) begin
      drive(tok0);
      if (j == 9) chk("lock_early", 32'(locked), 32'd0);
      if (j == 10) begin
        chk("lock0_locked", 32'(locked), 32'd1);
        chk("lock0_offset", 32'(offset), 32'd0);
        chk("lock0_c", 32'(out_c), 32'd0);
        chk("lock0_de", 32'(out_de), 32'd0);
      end
    end

    // Data and isolated tokens while locked; results 3 edges after input.
    for (int k = 0; k < 12; k++) begin
      drive((k < 10) ? dw[k] : 10'h1FF);
      if (k >= 2) begin
        chk($sformatf("dec%0d_data", k - 2), 32'(out_data), 32'(ex_d[k-2]));
        chk($sformatf("dec%0d_c", k - 2), 32'(out_c), 32'(ex_c[k-2]));
        chk($sformatf("dec%0d_de", k - 2), 32'(out_de), 32'(ex_de[k-2]));
      end
    end

    // No runs after lock at edge 10: lock drops at edge 10 + 4*2048.
    for (int j = 25; j <= 8202; j++) begin
      drive(10'h1FF);
      if (j == 8201) chk("loss_before", 32'(locked), 32'd1);
      if (j == 8202) begin
        chk("loss_at", 32'(locked), 32'd0);
        chk("loss_offset", 32'(offset), 32'd0);
`ifdef TMDS_DECODER_ERRCNT_EN
        chk("loss_err", 32'(err_count), 32'd4);
`endif
      end
    end

    // Stream delayed by 3 bits: three slips then lock at offset 3.
    reset = 1'b1;
    repeat (2) drive(10'h000);
    reset = 1'b0;
    for (int j = 1; j <= 6160; j++) begin
      drive(wd3);
      if (j == 2047) chk("slip_pre", 32'(offset), 32'd0);
      if (j == 2048) chk("slip1", 32'(offset), 32'd1);
      if (j == 4096) chk("slip2", 32'(offset), 32'd2);
      if (j == 6144) chk("slip3", 32'(offset), 32'd3);
      if (j == 6152) chk("slip_nolock", 32'(locked), 32'd0);
      if (j == 6153) begin
        chk("slip_lock", 32'(locked), 32'd1);
        chk("slip_lock_off", 32'(offset), 32'd3);
`ifdef TMDS_DECODER_ERRCNT_EN
        chk("slip_err", 32'(err_count), 32'd3);
`endif
      end
    end

    // Reset while locked at offset 3.
    reset = 1'b1;
    drive(wd3);
    chk_zero("rst_lock3");
`ifdef TMDS_DECODER_ERRCNT_EN
    chk("rst_lock3_err", 32'(err_count), 32'd0);
`endif
    reset = 1'b0;

    // Run completes exactly on the expiry edge of window 0: lock, no slip.
    for (int j = 1; j <= 2052; j++) begin
      drive((j < 2039) ? 10'h000 : tok0);
      if (j == 2047) begin
        chk("edge_nolock", 32'(locked), 32'd0);
        chk("edge_off_pre", 32'(offset), 32'd0);
      end
      if (j == 2048) begin
        chk("edge_lock", 32'(locked), 32'd1);
        chk("edge_off", 32'(offset), 32'd0);
`ifdef TMDS_DECODER_ERRCNT_EN
        chk("edge_err", 32'(err_count), 32'd0);
`endif
      end
    end

    reset = 1'b1;
    drive(tok0);
    chk_zero("rst_lock0");
    reset = 1'b0;
    drive(tok0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
